// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch responder.
// Holds the default word width, the no-op encoding returned on faulting fetches,
// the fetch FSM state type, and the wait-counter preload helper.
package instr_mem_responder_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE = 16;
    localparam int unsigned DEFAULT_ADDR_BITS = 8;

    // Instruction word returned when the fetch address is outside program memory
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_RESP = 2'd2
    } fetch_state_t;

    // Counter preload on acceptance; WAIT is skipped entirely when wait_cycles is 0
    function automatic logic [3:0] wait_init(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 4'd0 : 4'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch and program-load bus between the fetch stage / loader (master) and
// the instruction memory responder (slave).
//   fetch_req/fetch_addr       : fetch request, held until fetch_ready
//   fetch_ready                : responder accepts a request this cycle
//   instr_valid/instr/instr_fault : one-cycle response pulse with held data
//   load_en/load_addr/load_data: program-load write, held until load_ready
//   load_ready                 : load write accepted this cycle
interface instr_mem_responder_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_BITS = 8
);
    logic                 fetch_req;
    logic [WORD_SIZE-1:0] fetch_addr;
    logic                 fetch_ready;
    logic                 instr_valid;
    logic [WORD_SIZE-1:0] instr;
    logic                 instr_fault;
    logic                 load_en;
    logic [ADDR_BITS-1:0] load_addr;
    logic [WORD_SIZE-1:0] load_data;
    logic                 load_ready;

    modport master (
        output fetch_req, fetch_addr, load_en, load_addr, load_data,
        input  fetch_ready, instr_valid, instr, instr_fault, load_ready
    );

    modport slave (
        input  fetch_req, fetch_addr, load_en, load_addr, load_data,
        output fetch_ready, instr_valid, instr, instr_fault, load_ready
    );
endinterface

// File: rtl/instr_mem_responder_array.sv
// Program storage: 2**ADDR_BITS x WORD_SIZE words, synchronous write,
// combinational read. Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module instr_mem_array #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WORD_SIZE-1:0] rdata
);
    logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, waits WAIT_CYCLES
// wait states, then returns the instruction word (or NOP_INSTR with a fault
// flag when the address is beyond program memory). Also owns the program-load
// write port, which is only served while idle and no fetch is requested.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch/load bus, slave side
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int unsigned ADDR_BITS   = DEFAULT_ADDR_BITS,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_mem_responder_if.slave  bus
);
    localparam logic [3:0] WAIT_INIT = wait_init(WAIT_CYCLES);

    fetch_state_t         state;
    logic [3:0]           wait_cnt;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] read_addr;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 in_range;
    logic                 mem_we;
    logic                 instr_valid_q;
    logic [WORD_SIZE-1:0] instr_q;
    logic                 instr_fault_q;

    assign bus.fetch_ready = (state == FS_IDLE);
    assign bus.load_ready  = (state == FS_IDLE) && !bus.fetch_req;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_fault = instr_fault_q;

    assign mem_we = bus.load_en && bus.load_ready;

    // Entering RESP straight from IDLE (no wait states) happens on the same edge
    // that captures the address, so the read must bypass the capture register.
    always_comb begin
        read_addr = addr_q;
        if (state == FS_IDLE) begin
            read_addr = bus.fetch_addr;
        end
        in_range = ((read_addr >> ADDR_BITS) == '0);
    end

    instr_mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (read_addr[ADDR_BITS-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FS_IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_fault_q <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            case (state)
                FS_IDLE: begin
                    if (bus.fetch_req) begin
                        addr_q <= bus.fetch_addr;
                        if (WAIT_CYCLES == 0) begin
                            state         <= FS_RESP;
                            instr_valid_q <= 1'b1;
                            instr_q       <= in_range ? mem_rdata : WORD_SIZE'(NOP_INSTR);
                            instr_fault_q <= !in_range;
                        end else begin
                            state    <= FS_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                FS_WAIT: begin
                    if (wait_cnt == '0) begin
                        state         <= FS_RESP;
                        instr_valid_q <= 1'b1;
                        instr_q       <= in_range ? mem_rdata : WORD_SIZE'(NOP_INSTR);
                        instr_fault_q <= !in_range;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                FS_RESP: begin
                    state <= FS_IDLE;
                end
                default: begin
                    state <= FS_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: one instance with two wait states
// and one with none, sharing clock and reset.
module tb_instr_mem_responder;
    import instr_mem_responder_pkg::*;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    instr_mem_responder_if #(.WORD_SIZE(16), .ADDR_BITS(8)) bus2 ();
    instr_mem_responder_if #(.WORD_SIZE(16), .ADDR_BITS(8)) bus0 ();

    instr_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    instr_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load2(input logic [7:0] a, input logic [15:0] d);
        bus2.load_en   = 1'b1;
        bus2.load_addr = a;
        bus2.load_data = d;
        #1;
        check("load2_ready", 32'(bus2.load_ready), 32'd1);
        tick();
        bus2.load_en = 1'b0;
    endtask

    // Full fetch on the two-wait-state instance; optionally disturbs fetch_addr after acceptance
    task automatic fetch2(input string tag, input logic [15:0] a, input logic [15:0] exp_i,
                          input logic exp_f, input bit change_addr);
        bus2.fetch_req  = 1'b1;
        bus2.fetch_addr = a;
        #1;
        check({tag, "_ready_pre"}, 32'(bus2.fetch_ready), 32'd1);
        tick();
        bus2.fetch_req = 1'b0;
        if (change_addr) bus2.fetch_addr = a + 16'd1;
        check({tag, "_valid_t0"}, 32'(bus2.instr_valid), 32'd0);
        check({tag, "_ready_wait"}, 32'(bus2.fetch_ready), 32'd0);
        tick();
        check({tag, "_valid_t1"}, 32'(bus2.instr_valid), 32'd0);
        tick();
        check({tag, "_valid_t2"}, 32'(bus2.instr_valid), 32'd1);
        check({tag, "_instr"}, 32'(bus2.instr), 32'(exp_i));
        check({tag, "_fault"}, 32'(bus2.instr_fault), 32'(exp_f));
        check({tag, "_ready_resp"}, 32'(bus2.fetch_ready), 32'd0);
        tick();
        check({tag, "_valid_t3"}, 32'(bus2.instr_valid), 32'd0);
        check({tag, "_instr_hold"}, 32'(bus2.instr), 32'(exp_i));
        check({tag, "_ready_idle"}, 32'(bus2.fetch_ready), 32'd1);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus2.fetch_req = 1'b0; bus2.fetch_addr = '0;
        bus2.load_en = 1'b0; bus2.load_addr = '0; bus2.load_data = '0;
        bus0.fetch_req = 1'b0; bus0.fetch_addr = '0;
        bus0.load_en = 1'b0; bus0.load_addr = '0; bus0.load_data = '0;

        // Reset state
        #3;
        check("rst_valid", 32'(bus2.instr_valid), 32'd0);
        check("rst_instr", 32'(bus2.instr), 32'd0);
        check("rst_fault", 32'(bus2.instr_fault), 32'd0);
        check("rst_fetch_ready", 32'(bus2.fetch_ready), 32'd1);
        check("rst_load_ready", 32'(bus2.load_ready), 32'd1);
        #9 rst_n = 1'b1;
        tick();

        // Program load
        load2(8'd5, 16'hA5C3);
        load2(8'd6, 16'h1234);
        load2(8'd7, 16'hBEEF);

        // Basic fetch with two wait states
        fetch2("fetch5", 16'h0005, 16'hA5C3, 1'b0, 1'b0);
        // Address change after acceptance is ignored (6 captured, 7 presented)
        fetch2("capture", 16'h0006, 16'h1234, 1'b0, 1'b1);
        // Out-of-range address
        fetch2("range", 16'h0100, NOP_INSTR, 1'b1, 1'b0);

        // Load collides with fetch: fetch wins, load held and lands after response
        bus2.fetch_req  = 1'b1; bus2.fetch_addr = 16'h0007;
        bus2.load_en    = 1'b1; bus2.load_addr  = 8'd7; bus2.load_data = 16'hCAFE;
        #1;
        check("coll_load_ready", 32'(bus2.load_ready), 32'd0);
        tick();
        bus2.fetch_req = 1'b0;
        #1;
        check("coll_load_ready_wait", 32'(bus2.load_ready), 32'd0);
        tick();
        tick();
        check("coll_valid", 32'(bus2.instr_valid), 32'd1);
        check("coll_old_data", 32'(bus2.instr), 32'h0000BEEF);
        check("coll_load_ready_resp", 32'(bus2.load_ready), 32'd0);
        tick();
        check("coll_load_ready_idle", 32'(bus2.load_ready), 32'd1);
        tick();
        bus2.load_en = 1'b0;
        fetch2("coll_new", 16'h0007, 16'hCAFE, 1'b0, 1'b0);

        // Reset in the middle of WAIT aborts the fetch
        bus2.fetch_req = 1'b1; bus2.fetch_addr = 16'h0005;
        tick();
        bus2.fetch_req = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus2.instr_valid), 32'd0);
        check("mid_rst_instr", 32'(bus2.instr), 32'd0);
        check("mid_rst_fault", 32'(bus2.instr_fault), 32'd0);
        check("mid_rst_ready", 32'(bus2.fetch_ready), 32'd1);
        tick();
        check("mid_rst_valid_e1", 32'(bus2.instr_valid), 32'd0);
        tick();
        check("mid_rst_valid_e2", 32'(bus2.instr_valid), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(bus2.instr_valid), 32'd0);
        check("post_rst_ready", 32'(bus2.fetch_ready), 32'd1);
        // Memory survives reset
        fetch2("post_rst_fetch", 16'h0005, 16'hA5C3, 1'b0, 1'b0);

        // Zero wait states: back-to-back fetches of words 0 and 1
        bus0.load_en = 1'b1; bus0.load_addr = 8'd0; bus0.load_data = 16'h1111;
        tick();
        bus0.load_addr = 8'd1; bus0.load_data = 16'h2222;
        tick();
        bus0.load_en = 1'b0;
        bus0.fetch_req = 1'b1; bus0.fetch_addr = 16'h0000;
        tick();
        check("w0_valid_a", 32'(bus0.instr_valid), 32'd1);
        check("w0_instr_a", 32'(bus0.instr), 32'h00001111);
        check("w0_ready_resp", 32'(bus0.fetch_ready), 32'd0);
        bus0.fetch_addr = 16'h0001;
        tick();
        check("w0_valid_gap", 32'(bus0.instr_valid), 32'd0);
        check("w0_ready_idle", 32'(bus0.fetch_ready), 32'd1);
        check("w0_instr_hold", 32'(bus0.instr), 32'h00001111);
        tick();
        bus0.fetch_req = 1'b0;
        check("w0_valid_b", 32'(bus0.instr_valid), 32'd1);
        check("w0_instr_b", 32'(bus0.instr), 32'h00002222);
        check("w0_fault_b", 32'(bus0.instr_fault), 32'd0);
        tick();
        check("w0_valid_end", 32'(bus0.instr_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
